// File: rtl/iomem_initiator_pkg.sv
// Shared types and constants for the iomem initiator: FSM encoding, widths,
// the default timeout and the latched bus-request payload.
package iomem_initiator_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 16;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } iomem_req_t;

endpackage

// File: rtl/iomem_initiator_if.sv
// iomem bus between the initiator (master) and an IO responder (slave).
interface iomem_initiator_if;
  import iomem_initiator_pkg::*;

  logic              iomem_valid;
  logic              iomem_ready;
  logic [ADDR_W-1:0] iomem_addr;
  logic [DATA_W-1:0] iomem_wdata;
  logic [STRB_W-1:0] iomem_wstrb;
  logic [DATA_W-1:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_addr, iomem_wdata, iomem_wstrb,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_addr, iomem_wdata, iomem_wstrb,
    output iomem_ready, iomem_rdata
  );

endinterface

// File: rtl/iomem_initiator.sv
// Turns one cmd/rsp transaction at a time into an iomem bus access, with a
// bounded wait for the responder; a silent responder yields rsp_error.
module iomem_initiator
  import iomem_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,

  iomem_initiator_if.master bus
);

  // Counter value on which the wait expires; iomem_valid is then high for
  // exactly TIMEOUT_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state;
  iomem_req_t       req_q;
  logic [CNT_W-1:0] cnt;

  assign cmd_ready       = (state == ST_IDLE);
  assign rsp_valid       = (state == ST_RESP);
  assign bus.iomem_addr  = req_q.addr;
  assign bus.iomem_wdata = req_q.wdata;
  assign bus.iomem_wstrb = req_q.wstrb;

  // Ready is tested before expiry so a reply on the expiry edge completes normally.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      req_q           <= '0;
      cnt             <= '0;
      bus.iomem_valid <= 1'b0;
      rsp_rdata       <= '0;
      rsp_error       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            req_q           <= '{addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};
            cnt             <= '0;
            bus.iomem_valid <= 1'b1;
            state           <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (bus.iomem_ready) begin
            bus.iomem_valid <= 1'b0;
            rsp_rdata       <= bus.iomem_rdata;
            rsp_error       <= 1'b0;
            state           <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            bus.iomem_valid <= 1'b0;
            rsp_rdata       <= '0;
            rsp_error       <= 1'b1;
            state           <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          bus.iomem_valid <= 1'b0;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
